// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: constants, next-PC select codes and alignment helper.
// Used by the fetch stage (if_stage), which honours the optional IF_DELAY_SLOT_EN build macro.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'h0000_0004;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        SEQ = 2'b00,
        BR  = 2'b01,
        JR  = 2'b10,
        J   = 2'b11
    } pc_sel_e;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control/redirect inputs, instruction-memory port and the IF/ID outputs.
interface if_stage_if;

    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        j_taken_i;
    logic [31:0] j_target_i;
    logic        jr_taken_i;
    logic [31:0] jr_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc4_o;
    logic        id_valid_o;

    modport master (
        input  stall_i, br_taken_i, br_target_i, j_taken_i, j_target_i,
               jr_taken_i, jr_target_i, imem_rdata_i,
        output imem_addr_o, id_instr_o, id_pc4_o, id_valid_o
    );

    modport slave (
        output stall_i, br_taken_i, br_target_i, j_taken_i, j_target_i,
               jr_taken_i, jr_target_i, imem_rdata_i,
        input  imem_addr_o, id_instr_o, id_pc4_o, id_valid_o
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: stall holds, then branch, JR, J, else PC+4.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_taken,
    input  logic [31:0] jr_target,
    input  logic        j_taken,
    input  logic [31:0] j_target,
    output pc_sel_e     sel,
    output logic [31:0] next_pc
);

    logic taken_en_s;

    // Taken requests only count for a live, non-stalled instruction in ID
    always_comb begin
        taken_en_s = id_valid & ~stall;
        sel        = SEQ;
        if (taken_en_s & br_taken) begin
            sel = BR;
        end else if (taken_en_s & jr_taken) begin
            sel = JR;
        end else if (taken_en_s & j_taken) begin
            sel = J;
        end else begin
            sel = SEQ;
        end
    end

    // Resolve the selected source into a word-aligned next PC
    always_comb begin
        next_pc = word_align(pc + PC_INCR);
        if (stall) begin
            next_pc = pc;
        end else begin
            case (sel)
                SEQ:     next_pc = word_align(pc + PC_INCR);
                BR:      next_pc = word_align(br_target);
                JR:      next_pc = word_align(jr_target);
                J:       next_pc = word_align(j_target);
                default: next_pc = word_align(pc + PC_INCR);
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Build option IF_DELAY_SLOT_EN keeps the fetched delay-slot instruction on a redirect.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    bus
);

    logic [31:0] pc_r;
    logic [31:0] pc4_s;
    logic [31:0] next_pc_s;
    pc_sel_e     sel_s;
    logic        redirect_s;

    logic [31:0] id_instr_r;
    logic [31:0] id_pc4_r;
    logic        id_valid_r;
    logic [31:0] id_instr_nxt_s;
    logic [31:0] id_pc4_nxt_s;
    logic        id_valid_nxt_s;

    assign pc4_s      = pc_r + PC_INCR;
    assign redirect_s = (sel_s != SEQ);

    pc_next_sel u_pc_next_sel (
        .pc        (pc_r),
        .stall     (bus.stall_i),
        .id_valid  (id_valid_r),
        .br_taken  (bus.br_taken_i),
        .br_target (bus.br_target_i),
        .jr_taken  (bus.jr_taken_i),
        .jr_target (bus.jr_target_i),
        .j_taken   (bus.j_taken_i),
        .j_target  (bus.j_target_i),
        .sel       (sel_s),
        .next_pc   (next_pc_s)
    );

    // IF/ID next state: hold on stall, squash or keep delay slot on redirect
    always_comb begin
        id_instr_nxt_s = id_instr_r;
        id_pc4_nxt_s   = id_pc4_r;
        id_valid_nxt_s = id_valid_r;
        if (bus.stall_i) begin
            id_instr_nxt_s = id_instr_r;
            id_pc4_nxt_s   = id_pc4_r;
            id_valid_nxt_s = id_valid_r;
        end else if (redirect_s) begin
`ifdef IF_DELAY_SLOT_EN
            id_instr_nxt_s = bus.imem_rdata_i;
            id_valid_nxt_s = 1'b1;
`else
            id_instr_nxt_s = NOP_INSTR;
            id_valid_nxt_s = 1'b0;
`endif
            id_pc4_nxt_s   = pc4_s;
        end else begin
            id_instr_nxt_s = bus.imem_rdata_i;
            id_pc4_nxt_s   = pc4_s;
            id_valid_nxt_s = 1'b1;
        end
    end

    // PC and IF/ID state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= word_align(RESET_PC);
            id_instr_r <= NOP_INSTR;
            id_pc4_r   <= 32'h0000_0000;
            id_valid_r <= 1'b0;
        end else begin
            pc_r       <= next_pc_s;
            id_instr_r <= id_instr_nxt_s;
            id_pc4_r   <= id_pc4_nxt_s;
            id_valid_r <= id_valid_nxt_s;
        end
    end

    assign bus.imem_addr_o = pc_r;
    assign bus.id_instr_o  = id_instr_r;
    assign bus.id_pc4_o    = id_pc4_r;
    assign bus.id_valid_o  = id_valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expectations follow IF_DELAY_SLOT_EN if defined.
module tb_if_stage;
    import cpu_pkg::*;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory: combinational read of the fetch address
    always_comb bus.imem_rdata_i = mem_word(bus.imem_addr_o);

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        bus.stall_i    = 1'b0;
        bus.br_taken_i = 1'b0;
        bus.j_taken_i  = 1'b0;
        bus.jr_taken_i = 1'b0;
    endtask

    task automatic check_id(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        check_val({tag, "_instr"}, bus.id_instr_o, instr);
        check_val({tag, "_pc4"},   bus.id_pc4_o,   pc4);
        check_val({tag, "_valid"}, {31'h0, bus.id_valid_o}, {31'h0, valid});
    endtask

    initial begin
        rst_n           = 1'b0;
        clr_ctl();
        bus.br_target_i = 32'h0;
        bus.j_target_i  = 32'h0;
        bus.jr_target_i = 32'h0;
        #1;
        check_val("rst_addr", bus.imem_addr_o, 32'h0);
        check_id("rst", 32'h0, 32'h0, 1'b0);
        step();
        step();
        check_val("rst_hold_addr", bus.imem_addr_o, 32'h0);

        // Release with JR raised while ID is empty: must be ignored
        rst_n           = 1'b1;
        bus.jr_taken_i  = 1'b1;
        bus.jr_target_i = 32'h0000_0200;
        step();
        check_val("first_addr", bus.imem_addr_o, 32'h4);
        check_id("first", mem_word(32'h0), 32'h4, 1'b1);
        clr_ctl();
        step();
        check_val("seq_addr8", bus.imem_addr_o, 32'h8);
        check_val("seq_pc4_8", bus.id_pc4_o, 32'h8);
        step();
        step();
        check_val("seq_addr10", bus.imem_addr_o, 32'h10);
        check_id("seq10", mem_word(32'hC), 32'h10, 1'b1);

        bus.j_taken_i  = 1'b1;
        bus.j_target_i = 32'h0000_0100;
        step();
        check_val("jump_addr", bus.imem_addr_o, 32'h100);
        check_id("jump", DS ? mem_word(32'h10) : 32'h0, 32'h14, DS);
        clr_ctl();
        step();
        check_val("jump_next_addr", bus.imem_addr_o, 32'h104);
        check_id("jump_tgt", mem_word(32'h100), 32'h104, 1'b1);

        bus.j_taken_i  = 1'b1;
        bus.j_target_i = 32'h0000_0020;
        step();
        check_val("to20_addr", bus.imem_addr_o, 32'h20);
        clr_ctl();
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_addr", bus.imem_addr_o, 32'h20);
            check_id("stall", DS ? mem_word(32'h104) : 32'h0, 32'h108, DS);
        end
        bus.stall_i = 1'b0;
        step();
        check_val("unstall_addr", bus.imem_addr_o, 32'h24);
        check_id("unstall", mem_word(32'h20), 32'h24, 1'b1);

        bus.stall_i     = 1'b1;
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0080;
        step();
        check_val("stall_br_addr", bus.imem_addr_o, 32'h24);
        check_id("stall_br", mem_word(32'h20), 32'h24, 1'b1);
        bus.stall_i = 1'b0;
        step();
        check_val("br_addr", bus.imem_addr_o, 32'h80);
        check_id("br", DS ? mem_word(32'h24) : 32'h0, 32'h28, DS);
        clr_ctl();
        step();
        check_val("br_next_addr", bus.imem_addr_o, 32'h84);
        check_id("br_tgt", mem_word(32'h80), 32'h84, 1'b1);

        // Branch and jump together; branch wins and its low bits are dropped
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 32'h0000_0303;
        bus.j_taken_i   = 1'b1;
        bus.j_target_i  = 32'h0000_0400;
        step();
        check_val("br_prio_addr", bus.imem_addr_o, 32'h300);
        clr_ctl();
        step();
        check_val("br_prio_next", bus.imem_addr_o, 32'h304);

        bus.j_taken_i  = 1'b1;
        bus.j_target_i = 32'hFFFF_FFFC;
        step();
        check_val("wrap_top_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        clr_ctl();
        step();
        check_val("wrap_addr", bus.imem_addr_o, 32'h0);
        check_id("wrap", mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);

        bus.j_taken_i  = 1'b1;
        bus.j_target_i = 32'h0000_0040;
        step();
        check_val("to40_addr", bus.imem_addr_o, 32'h40);
        clr_ctl();
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_addr", bus.imem_addr_o, 32'h0);
        check_id("async_rst", 32'h0, 32'h0, 1'b0);
        #10;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
